// File: rtl/tl45_decode_fifo.sv
// Decoupled decode stage: a raw-instruction FIFO feeding a registered decode output
// over valid/ready, with legality checking and a trap that records the faulting PC.
module tl45_decode_fifo #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] LEGAL_MASK = 32'h003F_FFE7,
    parameter bit          ERR_STICKY = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [31:0]              i_pc,
    input  logic [31:0]              i_inst,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_pc,
    output logic [4:0]               o_opcode,
    output logic                     o_ri,
    output logic [3:0]               o_dr,
    output logic [3:0]               o_sr1,
    output logic [3:0]               o_sr2,
    output logic [31:0]              o_imm,
    output logic                     o_decode_err,
    output logic [31:0]              o_err_pc,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count;
    logic          full, empty, blocked, wr_en;
    logic          pop_illegal, load, pop;

    logic          valid_reg, err_reg, ri_reg;
    logic [31:0]   pc_reg, imm_reg, err_pc_reg;
    logic [4:0]    opcode_reg;
    logic [3:0]    dr_reg, sr1_reg, sr2_reg;

    // Head-of-queue fields
    logic [31:0]   head_pc, head_inst;
    logic [4:0]    h_op;
    logic          h_ri, h_lh, h_zs;
    logic [2:0]    h_mode;
    logic [3:0]    h_dr, h_sr1;
    logic [15:0]   h_imm16;
    logic          fields_ok, legal;
    logic [3:0]    dec_dr, dec_sr2;
    logic [31:0]   dec_imm;

    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (count == FULL_COUNT);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign blocked = ERR_STICKY && err_reg;
    assign o_ready = !full && !blocked;
    assign wr_en   = i_valid && o_ready && !i_flush;

    assign {head_pc, head_inst} = mem[rd_ptr_reg[AW-1:0]];
    assign h_op    = head_inst[31:27];
    assign h_ri    = head_inst[26];
    assign h_lh    = head_inst[25];
    assign h_zs    = head_inst[24];
    assign h_mode  = head_inst[26:24];
    assign h_dr    = head_inst[23:20];
    assign h_sr1   = head_inst[19:16];
    assign h_imm16 = head_inst[15:0];

    always_comb begin
        fields_ok = 1'b1;
        case (h_op)
            5'h00: fields_ok = (head_inst == 32'd0);
            5'h01, 5'h02, 5'h06, 5'h07, 5'h08:
                fields_ok = h_ri || (h_mode == 3'b000 && head_inst[11:0] == 12'd0);
            5'h09: fields_ok = (h_mode == 3'b000) && (head_inst[11:0] == 12'd0);
            5'h05, 5'h0A, 5'h0B:
                fields_ok = h_ri ? (h_imm16 < 16'd32) : (h_mode == 3'b000);
            5'h0C: fields_ok = (h_mode == 3'b101);
            5'h0D: fields_ok = (h_mode == 3'b000);
            5'h0E: fields_ok = (h_mode == 3'b000) && (h_dr == 4'hF) && (h_sr1 == 4'h0)
                               && (h_imm16 == 16'd0);
            5'h10: fields_ok = (h_mode == 3'b000) && (h_sr1 == 4'h0);
            5'h11: fields_ok = (h_mode == 3'b000) && (h_dr == 4'h0);
            5'h0F, 5'h12, 5'h13, 5'h14, 5'h15:
                fields_ok = (h_mode == 3'b001);
            default: fields_ok = 1'b1;
        endcase
        legal = LEGAL_MASK[h_op] && fields_ok;
    end

    // Stores carry their data register on sr2 so the write port field stays free
    always_comb begin
        dec_dr  = h_dr;
        dec_sr2 = h_ri ? 4'h0 : head_inst[15:12];
        case (h_op)
            5'h0D, 5'h0E: dec_sr2 = 4'hF;
            5'h13, 5'h15: begin
                dec_sr2 = h_dr;
                dec_dr  = 4'h0;
            end
            default: ;
        endcase
        if (h_lh)
            dec_imm = {h_imm16, 16'd0};
        else if (h_zs)
            dec_imm = {{16{h_imm16[15]}}, h_imm16};
        else
            dec_imm = {16'd0, h_imm16};
    end

    assign pop_illegal = !empty && !blocked && !legal;
    assign load        = !empty && !blocked && legal && (!valid_reg || i_ready);
    assign pop         = pop_illegal || load;

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr_reg[AW-1:0]] <= {i_pc, i_inst};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            valid_reg  <= 1'b0;
            pc_reg     <= '0;
            opcode_reg <= '0;
            ri_reg     <= 1'b0;
            dr_reg     <= '0;
            sr1_reg    <= '0;
            sr2_reg    <= '0;
            imm_reg    <= '0;
            err_reg    <= 1'b0;
            if (i_reset)
                err_pc_reg <= '0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (load) begin
                valid_reg  <= 1'b1;
                pc_reg     <= head_pc;
                opcode_reg <= h_op;
                ri_reg     <= h_ri;
                dr_reg     <= dec_dr;
                sr1_reg    <= h_sr1;
                sr2_reg    <= dec_sr2;
                imm_reg    <= dec_imm;
            end else if (valid_reg && i_ready) begin
                valid_reg  <= 1'b0;
            end
            if (pop_illegal) begin
                err_reg <= 1'b1;
                if (!err_reg)
                    err_pc_reg <= head_pc;
            end
        end
    end

    assign o_valid      = valid_reg;
    assign o_pc         = pc_reg;
    assign o_opcode     = opcode_reg;
    assign o_ri         = ri_reg;
    assign o_dr         = dr_reg;
    assign o_sr1        = sr1_reg;
    assign o_sr2        = sr2_reg;
    assign o_imm        = imm_reg;
    assign o_decode_err = err_reg;
    assign o_err_pc     = err_pc_reg;
    assign o_count      = count;
endmodule

// File: tb/tb_tl45_decode_fifo.sv
// Bench for tl45_decode_fifo: directed scenarios followed by random traffic, every
// cycle compared against a queue-based model of the decode stage.
module tb_tl45_decode_fifo;
    localparam int          DEPTH = 4;
    localparam logic [31:0] MASK  = 32'h003F_FFE7;
    localparam logic [31:0] ADD_I = 32'h0812_3000;

    logic        i_clk = 1'b0;
    logic        i_reset, i_flush, i_valid, i_ready;
    logic [31:0] i_pc, i_inst;
    logic        o_ready, o_valid, o_ri, o_decode_err;
    logic [31:0] o_pc, o_imm, o_err_pc;
    logic [4:0]  o_opcode;
    logic [3:0]  o_dr, o_sr1, o_sr2;
    logic [2:0]  o_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    always #5 i_clk = ~i_clk;

    tl45_decode_fifo #(.DEPTH(DEPTH), .LEGAL_MASK(MASK), .ERR_STICKY(1'b1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc), .i_inst(i_inst),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_opcode(o_opcode),
        .o_ri(o_ri), .o_dr(o_dr), .o_sr1(o_sr1), .o_sr2(o_sr2), .o_imm(o_imm),
        .o_decode_err(o_decode_err), .o_err_pc(o_err_pc), .o_count(o_count)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic        ri;
        logic [3:0]  dr;
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic [31:0] imm;
    } dec_t;

    logic [63:0] mq[$];
    bit          m_valid, m_err;
    dec_t        m_dec;
    logic [31:0] m_pc, m_err_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_legal(logic [31:0] inst);
        int          op   = int'(inst[31:27]);
        int          mode = int'(inst[26:24]);
        int          imm  = int'(inst[15:0]);
        int          dr   = int'(inst[23:20]);
        int          sr1  = int'(inst[19:16]);
        int          low  = int'(inst[11:0]);
        bit          ri   = inst[26];
        if (!MASK[op]) return 0;
        if (op == 0) return inst == 32'd0;
        if (op inside {1, 2, 6, 7, 8}) return ri || (mode == 0 && low == 0);
        if (op == 9) return mode == 0 && low == 0;
        if (op inside {5, 10, 11}) return ri ? (imm < 32) : (mode == 0);
        if (op == 12) return mode == 5;
        if (op == 13) return mode == 0;
        if (op == 14) return mode == 0 && dr == 15 && sr1 == 0 && imm == 0;
        if (op == 16) return mode == 0 && sr1 == 0;
        if (op == 17) return mode == 0 && dr == 0;
        if (op inside {15, 18, 19, 20, 21}) return mode == 1;
        return 1;
    endfunction

    function automatic dec_t ref_decode(logic [31:0] inst);
        dec_t d;
        int   op = int'(inst[31:27]);
        d.op  = inst[31:27];
        d.ri  = inst[26];
        d.dr  = inst[23:20];
        d.sr1 = inst[19:16];
        d.sr2 = inst[26] ? 4'h0 : inst[15:12];
        if (op == 13 || op == 14) d.sr2 = 4'hF;
        if (op == 19 || op == 21) begin
            d.sr2 = inst[23:20];
            d.dr  = 4'h0;
        end
        if (inst[25])
            d.imm = 32'(int'(inst[15:0]) * 65536);
        else if (inst[24] && inst[15])
            d.imm = 32'(int'(inst[15:0]) - 65536);
        else
            d.imm = 32'(int'(inst[15:0]));
        return d;
    endfunction

    task automatic model_edge();
        bit          accept;
        logic [63:0] h;
        if (i_reset || i_flush) begin
            mq.delete();
            m_valid = 0;
            m_dec   = '0;
            m_pc    = '0;
            m_err   = 0;
            if (i_reset) m_err_pc = '0;
        end else begin
            accept = i_valid && !m_err && (mq.size() < DEPTH);
            if (mq.size() > 0 && !m_err) begin
                h = mq[0];
                if (!ref_legal(h[31:0])) begin
                    void'(mq.pop_front());
                    m_err_pc = h[63:32];
                    m_err    = 1;
                    if (m_valid && i_ready) m_valid = 0;
                end else if (!m_valid || i_ready) begin
                    void'(mq.pop_front());
                    m_valid = 1;
                    m_pc    = h[63:32];
                    m_dec   = ref_decode(h[31:0]);
                end
            end else if (m_valid && i_ready) begin
                m_valid = 0;
            end
            if (accept) mq.push_back({i_pc, i_inst});
        end
    endtask

    task automatic compare_all();
        check("valid",  64'(o_valid),      64'(m_valid));
        check("ready",  64'(o_ready),      64'((mq.size() < DEPTH) && !m_err));
        check("count",  64'(o_count),      64'(mq.size()));
        check("pc",     64'(o_pc),         64'(m_pc));
        check("opcode", 64'(o_opcode),     64'(m_dec.op));
        check("ri",     64'(o_ri),         64'(m_dec.ri));
        check("dr",     64'(o_dr),         64'(m_dec.dr));
        check("sr1",    64'(o_sr1),        64'(m_dec.sr1));
        check("sr2",    64'(o_sr2),        64'(m_dec.sr2));
        check("imm",    64'(o_imm),        64'(m_dec.imm));
        check("err",    64'(o_decode_err), 64'(m_err));
        check("err_pc", 64'(o_err_pc),     64'(m_err_pc));
    endtask

    task automatic step();
        @(negedge i_clk);
        if (chk_en) compare_all();
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] gen_inst();
        int          ops[20] = '{0, 1, 2, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21};
        logic [31:0] x = $urandom;
        int          op;
        if ($urandom_range(0, 99) < 5) return x;
        op = ops[$urandom_range(0, 19)];
        x[31:27] = op[4:0];
        case (op)
            0:             x = 32'd0;
            1, 2, 6, 7, 8: if (!x[26]) begin x[25:24] = 2'b00; x[11:0] = 12'd0; end
            9:             begin x[26:24] = 3'b000; x[11:0] = 12'd0; end
            5, 10, 11:     if (x[26]) x[15:0] = 16'($urandom_range(0, 31)); else x[25:24] = 2'b00;
            12:            x[26:24] = 3'b101;
            13:            x[26:24] = 3'b000;
            14:            x = 32'h70F0_0000;
            16:            begin x[26:24] = 3'b000; x[19:16] = 4'h0; end
            17:            begin x[26:24] = 3'b000; x[23:20] = 4'h0; end
            default:       x[26:24] = 3'b001;
        endcase
        return x;
    endfunction

    initial begin
        i_reset = 1; i_flush = 0; i_valid = 0; i_ready = 0; i_pc = '0; i_inst = '0;
        step(); step();
        chk_en = 1; i_reset = 0;
        check("rst_valid", 64'(o_valid), 0);
        check("rst_count", 64'(o_count), 0);
        check("rst_err",   64'(o_decode_err), 0);
        check("rst_errpc", 64'(o_err_pc), 0);
        check("rst_ready", 64'(o_ready), 1);

        // single ADD r1,r2,r3
        i_ready = 1; i_valid = 1; i_pc = 32'h40; i_inst = ADD_I;
        step();
        i_valid = 0;
        check("lat_not_yet", 64'(o_valid), 0);
        step();
        check("add_valid", 64'(o_valid), 1);
        check("add_pc",    64'(o_pc), 64'h40);
        check("add_op",    64'(o_opcode), 1);
        check("add_dr",    64'(o_dr), 1);
        check("add_sr1",   64'(o_sr1), 2);
        check("add_sr2",   64'(o_sr2), 3);
        check("add_imm",   64'(o_imm), 64'h3000);
        step();
        check("add_gone",  64'(o_valid), 0);

        // back-to-back stream
        for (int i = 0; i < 9; i++) begin
            i_valid = (i < 8); i_pc = 32'h100 + 32'(4 * i); i_inst = ADD_I;
            step();
            if (i >= 1) begin
                check("stream_valid", 64'(o_valid), 1);
                check("stream_pc",    64'(o_pc), 64'(32'h100 + 32'(4 * (i - 1))));
            end
            check("stream_cnt_le1", 64'(o_count <= 3'd1), 1);
        end
        i_valid = 0;
        step();

        // fill under backpressure, overflow attempts rejected
        i_ready = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            i_valid = 1; i_pc = 32'h200 + 32'(4 * i); i_inst = ADD_I;
            step();
        end
        check("full_count", 64'(o_count), DEPTH);
        check("full_ready", 64'(o_ready), 0);
        i_valid = 0; i_ready = 1;
        for (int k = 0; k <= DEPTH; k++) begin
            check("drain_valid", 64'(o_valid), 1);
            check("drain_pc",    64'(o_pc), 64'(32'h200 + 32'(4 * k)));
            step();
        end
        check("drain_end", 64'(o_valid), 0);

        // store remap and RET
        i_valid = 1; i_pc = 32'h300; i_inst = 32'hA952_0004;
        step();
        i_pc = 32'h304; i_inst = 32'h70F0_0000;
        step();
        i_valid = 0;
        check("sw_op",  64'(o_opcode), 64'h15);
        check("sw_dr",  64'(o_dr), 0);
        check("sw_sr1", 64'(o_sr1), 2);
        check("sw_sr2", 64'(o_sr2), 5);
        check("sw_imm", 64'(o_imm), 4);
        step();
        check("ret_pc",  64'(o_pc), 64'h304);
        check("ret_op",  64'(o_opcode), 64'h0E);
        check("ret_dr",  64'(o_dr), 64'hF);
        check("ret_sr2", 64'(o_sr2), 64'hF);
        step();

        // illegal opcode trap, then flush
        i_valid = 1; i_pc = 32'h80; i_inst = 32'hF800_0000;
        step();
        i_valid = 0;
        step();
        check("trap_err",   64'(o_decode_err), 1);
        check("trap_errpc", 64'(o_err_pc), 64'h80);
        check("trap_ready", 64'(o_ready), 0);
        check("trap_valid", 64'(o_valid), 0);
        i_valid = 1; i_pc = 32'h84; i_inst = ADD_I;
        step();
        check("trap_blocked", 64'(o_count), 0);
        i_valid = 0; i_flush = 1;
        step();
        i_flush = 0;
        check("flush_err",   64'(o_decode_err), 0);
        check("flush_ready", 64'(o_ready), 1);
        check("flush_errpc", 64'(o_err_pc), 64'h80);

        // flush with queued ops and a held output, simultaneous push dropped
        i_ready = 0;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1; i_pc = 32'h400 + 32'(4 * i); i_inst = ADD_I;
            step();
        end
        check("preflush_cnt",   64'(o_count), 3);
        check("preflush_valid", 64'(o_valid), 1);
        i_flush = 1; i_valid = 1; i_pc = 32'h500;
        step();
        i_flush = 0; i_valid = 0;
        check("postflush_cnt",   64'(o_count), 0);
        check("postflush_valid", 64'(o_valid), 0);
        check("postflush_pc",    64'(o_pc), 0);
        step();
        check("postflush_cnt2",  64'(o_count), 0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            i_reset = ($urandom_range(0, 199) == 0);
            i_flush = ($urandom_range(0, 99) < (m_err ? 25 : 3));
            i_valid = ($urandom_range(0, 99) < 70);
            i_ready = ($urandom_range(0, 99) < 65);
            i_pc    = $urandom;
            i_inst  = gen_inst();
            step();
        end
        i_reset = 0; i_flush = 0; i_valid = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
